algo_mapt_ready_bp_ctrl: RTL and testbench

ALGO_MAPT_READY_BP_CTRL -- requirements
Module: algo_mapt_ready_bp_ctrl

---
 rtl/algo_mapt_ready_bp_ctrl_pkg.sv | 18 +
 rtl/algo_mapt_bp_cnt.sv | 65 ++++++
 rtl/algo_mapt_ready_bp_ctrl.sv | 103 ++++++++++
 tb/tb_algo_mapt_ready_bp_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/algo_mapt_ready_bp_ctrl_pkg.sv
// Shared constants and the readiness FSM encoding for the memory-access-port
// ready/backpressure controller.
package algo_mapt_ready_bp_ctrl_pkg;

    localparam int unsigned DEF_NUMMAPT = 16;
    localparam int unsigned DEF_BITCNT  = 11;
    localparam int unsigned DEF_RDYSTBL = 4;

    // Settle counter width covers the full 1..255 stability window.
    localparam int unsigned STBL_W = 8;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RDY    = 2'd2
    } rdy_state_e;

endpackage

// File: rtl/algo_mapt_bp_cnt.sv
// One port's outstanding-read counter with saturation, floor, sticky error
// flags and threshold/hysteresis backpressure.
module algo_mapt_bp_cnt
    import algo_mapt_ready_bp_ctrl_pkg::*;
#(
    parameter int unsigned BITCNT = DEF_BITCNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_ev,
    input  logic              cm_ev,
    input  logic [BITCNT-1:0] bp_thr,
    input  logic [BITCNT-1:0] bp_hys,
    output logic [BITCNT-1:0] cnt,
    output logic              bp,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam logic [BITCNT-1:0] CNT_MAX = {BITCNT{1'b1}};
    localparam logic [BITCNT-1:0] CNT_MIN = '0;

    logic [BITCNT-1:0] cnt_q, cnt_d;
    logic              bp_q, bp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    // Simultaneous read and completion cancel; the assert rule has priority
    // over release so overlapping thresholds reduce to count >= bp_thr.
    always_comb begin
        cnt_d = cnt_q;
        bp_d  = bp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (rd_ev && !cm_ev) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + BITCNT'(1);
        end else if (cm_ev && !rd_ev) begin
            if (cnt_q == CNT_MIN) unf_d = 1'b1;
            else                  cnt_d = cnt_q - BITCNT'(1);
        end
        if (cnt_d >= bp_thr)      bp_d = 1'b1;
        else if (cnt_d <= bp_hys) bp_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            bp_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bp_q  <= bp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign cnt     = cnt_q;
    assign bp      = bp_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;

endmodule

// File: rtl/algo_mapt_ready_bp_ctrl.sv
// Qualifies raw core readiness through a stability window and tracks
// per-port outstanding reads with backpressure and sticky error reporting.
module algo_mapt_ready_bp_ctrl
    import algo_mapt_ready_bp_ctrl_pkg::*;
#(
    parameter int unsigned NUMMAPT = DEF_NUMMAPT,
    parameter int unsigned BITCNT  = DEF_BITCNT,
    parameter int unsigned RDYSTBL = DEF_RDYSTBL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ready_int,
    input  logic [NUMMAPT-1:0]        ma_vld,
    input  logic [NUMMAPT-1:0]        ma_write,
    input  logic [NUMMAPT-1:0]        dq_vld,
    input  logic [BITCNT-1:0]         bp_thr,
    input  logic [BITCNT-1:0]         bp_hys,
    output logic                      ready,
    output logic [NUMMAPT-1:0]        ma_bp,
    output logic [NUMMAPT*BITCNT-1:0] ma_cnt,
    output logic [NUMMAPT-1:0]        err_ovf,
    output logic [NUMMAPT-1:0]        err_unf,
    output logic                      err_nrdy
);

    localparam logic [STBL_W-1:0] STBL_LAST = STBL_W'(RDYSTBL - 1);

    rdy_state_e        state_q, state_d;
    logic [STBL_W-1:0] stbl_q, stbl_d;
    logic              ready_q, ready_d;
    logic              err_nrdy_q, err_nrdy_d;
    logic [NUMMAPT-1:0] rd_ev;

    // Readiness FSM: the cycle leaving reset is never counted as stable.
    always_comb begin
        state_d    = state_q;
        stbl_d     = stbl_q;
        err_nrdy_d = err_nrdy_q | ((|ma_vld) & ~ready_q);
        unique case (state_q)
            ST_RST: begin
                state_d = ST_SETTLE;
                stbl_d  = '0;
            end
            ST_SETTLE: begin
                if (!ready_int) begin
                    stbl_d = '0;
                end else if (stbl_q == STBL_LAST) begin
                    state_d = ST_RDY;
                    stbl_d  = '0;
                end else begin
                    stbl_d = stbl_q + STBL_W'(1);
                end
            end
            ST_RDY: begin
                if (!ready_int) begin
                    state_d = ST_SETTLE;
                    stbl_d  = '0;
                end
            end
            default: begin
                state_d = ST_RST;
                stbl_d  = '0;
            end
        endcase
        ready_d = (state_d == ST_RDY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RST;
            stbl_q     <= '0;
            ready_q    <= 1'b0;
            err_nrdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stbl_q     <= stbl_d;
            ready_q    <= ready_d;
            err_nrdy_q <= err_nrdy_d;
        end
    end

    assign rd_ev    = ma_vld & ~ma_write & {NUMMAPT{ready_q}};
    assign ready    = ready_q;
    assign err_nrdy = err_nrdy_q;

    for (genvar p = 0; p < NUMMAPT; p++) begin : g_port
        algo_mapt_bp_cnt #(
            .BITCNT (BITCNT)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .rd_ev   (rd_ev[p]),
            .cm_ev   (dq_vld[p]),
            .bp_thr  (bp_thr),
            .bp_hys  (bp_hys),
            .cnt     (ma_cnt[p*BITCNT +: BITCNT]),
            .bp      (ma_bp[p]),
            .err_ovf (err_ovf[p]),
            .err_unf (err_unf[p])
        );
    end

endmodule

// File: tb/tb_algo_mapt_ready_bp_ctrl.sv
// Self-checking bench: directed corner sequences, a vector table for the
// hysteresis walk, and randomized traffic against a behavioural model.
module tb_algo_mapt_ready_bp_ctrl;

    localparam int NP = 16;
    localparam int BC = 11;
    localparam int STBL = 4;
    localparam int CMAX = (1 << BC) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready_int = 1'b0;
    logic [NP-1:0] ma_vld = '0, ma_write = '0, dq_vld = '0;
    logic [BC-1:0] bp_thr = 11'd8, bp_hys = 11'd3;
    logic ready, err_nrdy;
    logic [NP-1:0] ma_bp, err_ovf, err_unf;
    logic [NP*BC-1:0] ma_cnt;

    // Narrow-counter instance for saturation boundaries.
    logic [NP-1:0] vld3 = '0, wr3 = '0, dq3 = '0;
    logic [2:0] thr3 = 3'd7, hys3 = 3'd0;
    logic ready3, err_nrdy3;
    logic [NP-1:0] ma_bp3, err_ovf3, err_unf3;
    logic [NP*3-1:0] ma_cnt3;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int m_cnt[NP];
    bit m_bp[NP], m_ovf[NP], m_unf[NP];
    bit m_nrdy, m_ready, m_live;
    int m_run;

    typedef struct {
        logic rd;
        logic cm;
        int   exp_cnt;
        logic exp_bp;
    } hys_vec_t;
    hys_vec_t hys_tab[13];

    always #5 clk = ~clk;

    algo_mapt_ready_bp_ctrl dut (
        .clk(clk), .rst(rst), .ready_int(ready_int), .ma_vld(ma_vld),
        .ma_write(ma_write), .dq_vld(dq_vld), .bp_thr(bp_thr), .bp_hys(bp_hys),
        .ready(ready), .ma_bp(ma_bp), .ma_cnt(ma_cnt), .err_ovf(err_ovf),
        .err_unf(err_unf), .err_nrdy(err_nrdy)
    );

    algo_mapt_ready_bp_ctrl #(.NUMMAPT(NP), .BITCNT(3), .RDYSTBL(STBL)) dut3 (
        .clk(clk), .rst(rst), .ready_int(ready_int), .ma_vld(vld3),
        .ma_write(wr3), .dq_vld(dq3), .bp_thr(thr3), .bp_hys(hys3),
        .ready(ready3), .ma_bp(ma_bp3), .ma_cnt(ma_cnt3), .err_ovf(err_ovf3),
        .err_unf(err_unf3), .err_nrdy(err_nrdy3)
    );

    task automatic chk(input string nm, input logic [NP*BC-1:0] act, input logic [NP*BC-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            m_cnt[p] = 0; m_bp[p] = 0; m_ovf[p] = 0; m_unf[p] = 0;
        end
        m_nrdy = 0; m_ready = 0; m_live = 0; m_run = 0;
    endtask

    // Ready is high once the last STBL samples after reset exit were all high.
    task automatic model_edge();
        for (int p = 0; p < NP; p++) begin
            bit rd, cm;
            rd = m_ready && ma_vld[p] && !ma_write[p];
            cm = dq_vld[p];
            if (rd && !cm) begin
                if (m_cnt[p] == CMAX) m_ovf[p] = 1; else m_cnt[p]++;
            end else if (cm && !rd) begin
                if (m_cnt[p] == 0) m_unf[p] = 1; else m_cnt[p]--;
            end
            if (m_cnt[p] >= int'(bp_thr)) m_bp[p] = 1;
            else if (m_cnt[p] <= int'(bp_hys)) m_bp[p] = 0;
        end
        if ((ma_vld != 0) && !m_ready) m_nrdy = 1;
        if (!m_live) m_live = 1;
        else if (ready_int) begin if (m_run < 1000) m_run++; end
        else m_run = 0;
        m_ready = (m_run >= STBL);
    endtask

    task automatic check_all(input string tag);
        logic [NP*BC-1:0] ec;
        logic [NP-1:0] eb, eo, eu;
        for (int p = 0; p < NP; p++) begin
            ec[p*BC +: BC] = BC'(m_cnt[p]);
            eb[p] = m_bp[p]; eo[p] = m_ovf[p]; eu[p] = m_unf[p];
        end
        chk({tag, ".ready"}, NP*BC'(ready), NP*BC'(m_ready));
        chk({tag, ".ma_cnt"}, ma_cnt, ec);
        chk({tag, ".ma_bp"}, NP*BC'(ma_bp), NP*BC'(eb));
        chk({tag, ".err_ovf"}, NP*BC'(err_ovf), NP*BC'(eo));
        chk({tag, ".err_unf"}, NP*BC'(err_unf), NP*BC'(eu));
        chk({tag, ".err_nrdy"}, NP*BC'(err_nrdy), NP*BC'(m_nrdy));
    endtask

    task automatic step(input string tag, input logic ri, input logic [NP-1:0] v,
                        input logic [NP-1:0] w, input logic [NP-1:0] d);
        ready_int = ri; ma_vld = v; ma_write = w; dq_vld = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #1;
        check_all("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        for (int i = 0; i < 8; i++) hys_tab[i] = '{1'b1, 1'b0, i + 1, (i + 1) >= 8};
        for (int i = 0; i < 5; i++) hys_tab[8 + i] = '{1'b0, 1'b1, 7 - i, (7 - i) > 3};

        // Settle from reset with ready_int high; early requests are refused.
        @(posedge clk); #1;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step("settle", 1'b1, (k <= 2) ? 16'hFFFF : 16'h0, '0, '0);
            chk("settle_ready", NP*BC'(ready), NP*BC'(k >= 5));
        end
        chk("nrdy_sticky", NP*BC'(err_nrdy), NP*BC'(1));
        chk("nrdy_no_count", ma_cnt, '0);

        // Glitch low on the second settle sample restarts the window.
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            step("glitch", (k != 3), '0, '0, '0);
            chk("glitch_ready", NP*BC'(ready), NP*BC'(k >= 7));
        end

        // Hysteresis walk on port 5 with thr=8, hys=3.
        bp_thr = 11'd8; bp_hys = 11'd3;
        for (int i = 0; i < 13; i++) begin
            step("hys", 1'b1, hys_tab[i].rd ? 16'h0020 : 16'h0,
                 '0, hys_tab[i].cm ? 16'h0020 : 16'h0);
            chk($sformatf("hys_cnt5[%0d]", i), NP*BC'(ma_cnt[5*BC +: BC]), NP*BC'(hys_tab[i].exp_cnt));
            chk($sformatf("hys_bp5[%0d]", i), NP*BC'(ma_bp[5]), NP*BC'(hys_tab[i].exp_bp));
        end

        // Simultaneous read and completion on port 0 at count 6.
        for (int i = 0; i < 6; i++) step("fill0", 1'b1, 16'h0001, '0, '0);
        chk("cnt0_six", NP*BC'(ma_cnt[BC-1:0]), NP*BC'(6));
        step("simul", 1'b1, 16'h0001, '0, 16'h0001);
        chk("simul_cnt0", NP*BC'(ma_cnt[BC-1:0]), NP*BC'(6));
        chk("simul_bp0", NP*BC'(ma_bp[0]), NP*BC'(0));
        step("wr_only", 1'b1, 16'h0001, 16'h0001, '0);
        chk("write_ignored", NP*BC'(ma_cnt[BC-1:0]), NP*BC'(6));
        for (int i = 0; i < 2; i++) step("fill0b", 1'b1, 16'h0001, '0, '0);
        chk("bp0_high", NP*BC'(ma_bp[0]), NP*BC'(1));

        // Asynchronous reset mid-operation clears everything before the next edge.
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("async_cnt", ma_cnt, '0);
        chk("async_bp", NP*BC'(ma_bp), '0);
        chk("async_ready", NP*BC'(ready), '0);
        chk("async_err", NP*BC'({err_ovf, err_unf, err_nrdy}), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) step("resettle", 1'b1, '0, '0, '0);

        // Saturation and floor on the 3-bit instance.
        chk("dut3_ready", NP*BC'(ready3), NP*BC'(1));
        vld3 = 16'h0001;
        for (int i = 0; i < 8; i++) step("sat", 1'b1, '0, '0, '0);
        vld3 = '0; dq3 = 16'h0002;
        step("floor", 1'b1, '0, '0, '0);
        dq3 = '0;
        chk("sat_cnt0", NP*BC'(ma_cnt3[2:0]), NP*BC'(7));
        chk("sat_ovf0", NP*BC'(err_ovf3[0]), NP*BC'(1));
        chk("sat_bp0", NP*BC'(ma_bp3[0]), NP*BC'(1));
        chk("floor_cnt1", NP*BC'(ma_cnt3[5:3]), NP*BC'(0));
        chk("floor_unf1", NP*BC'(err_unf3[1]), NP*BC'(1));
        chk("dut3_flags", NP*BC'({err_ovf3[15:1], err_unf3[0], err_unf3[15:2], err_nrdy3}), '0);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            logic [NP-1:0] d;
            if (c % 250 == 0) begin
                bp_thr = BC'($urandom_range(0, 20));
                bp_hys = BC'($urandom_range(0, 20));
            end
            if ((c / 500) % 2 == 0) d = NP'($urandom & $urandom & $urandom);
            else                    d = NP'($urandom | $urandom);
            step("rand", ($urandom_range(0, 9) != 0), NP'($urandom), NP'($urandom), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
